vector_xing_rx_arb: RTL and testbench
=====================================

// Module: vector_xing_rx_arb
// PURPOSE
//  Multi-channel receive side of a two-phase toggle handshake for moving held data vectors into the clk domain.
//  Each of N far-domain senders holds a data vector stable and flips its request toggle.
//  This block synchronises every toggle and round-robin arbitrates pending channels.
//  It captures the selected vector into a FIFO, returns a per-channel ack toggle and emits {chan, data} on ready/valid.
// PARAMETERS
//  NUM_CHAN     4   number of sender channels, >=1
//  DATA_WIDTH   32  width of each channel's data vector
//  FIFO_DEPTH   8   output FIFO entries, power of 2, >=2
//  SYNC_STAGES  2   flops per request-toggle synchroniser, >=2
// PORTS
//  clk        in   1                     the single clock; all outputs synchronous to it
//  reset      in   1                     asynchronous, active-high reset
//  req_tgl    in   NUM_CHAN              per-channel request toggles, asynchronous to clk
//  req_data   in   NUM_CHAN*DATA_WIDTH   channel c at [c*DATA_WIDTH +: DATA_WIDTH]; stable while c pending
//  ack_tgl    out  NUM_CHAN              per-channel ack toggles, registered, for far-domain sync
//  odata      out  DATA_WIDTH            head-of-FIFO data
//  ochan      out  $clog2(NUM_CHAN)>=1   channel index of odata
//  ovalid     out  1                     odata/ochan valid
//  oready     in   1                     consumer accepts when ovalid && oready
//  olevel     out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  ocount     out  NUM_CHAN*16           per-channel delivered counts (VECTOR_XING_RX_ARB_COUNT_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - all synchroniser flops and ack_tgl = 0; FIFO empty.
//    - ovalid=0, olevel=0, odata=0, ochan=0, ocount=0.
//  - pending[c] = req_sync[c] ^ ack_tgl[c]; req_sync is the SYNC_STAGES-flop output.
//  - Arbiter: round-robin over pending. Search starts at last_grant+1 mod NUM_CHAN. last_grant resets to NUM_CHAN-1.
//  - Capture cycle: some channel pending and olevel < FIFO_DEPTH. Same edge:
//    - push {grant, req_data[grant]};
//    - flip ack_tgl[grant];
//    - last_grant <= grant.
//  - At most one capture per cycle. A granted channel is not pending the next cycle.
//  - Full (olevel==FIFO_DEPTH): no capture, no ack flip; pending held. A pop on the same cycle does not enable the push (no bypass).
//  - Pop on ovalid && oready. Push and pop on the same cycle leave olevel unchanged.
//  - Latency, idle FIFO: ovalid rises SYNC_STAGES+2 clk edges after the first edge that samples a req_tgl flip.
//  - Output is first-word-fall-through, from registered FIFO state; no combinational path oready->ovalid.
//  - Order: per-channel order preserved. Cross-channel order = grant order.
//  - Toggle protocol: a sender must not flip req_tgl again until its synchronised ack_tgl equals req_tgl. Violations are undefined.
//  - Reset mid-operation: FIFO contents are discarded. A channel with req_tgl=1 at reset release is pending once and delivered once.
//  - Pointer wrap: read/write pointers carry an extra MSB for full/empty.
// CONFIGURATION
//  - VECTOR_XING_RX_ARB_COUNT_EN defined:
//    - per-channel 16-bit counter increments on each capture of that channel, wraps 0xFFFF->0.
//    - counters drive ocount; reset to 0.
//  - Not defined: ocount is tied to 0 and no counter flops exist.
// STRUCTURE
//  - vector_xing_pkg holds:
//    - function clog2_min1(n), returning max($clog2(n),1);
//    - localparam COUNT_WIDTH = 16;
//    - typedef-free helpers only; widths come from parameters.
//  - Sub-module toggle_sync: one SYNC_STAGES-deep bit synchroniser with async reset, instantiated per channel.
//  - The arbiter and FIFO stay inline in this module.
// TESTING
//  1. Single event, NUM_CHAN=4, SYNC_STAGES=2: req_data[1]=0xDEADBEEF, flip req_tgl[1]
//     -> ovalid after 4 edges, odata=0xDEADBEEF, ochan=1; ack_tgl[1]=1.
//  2. All channels at once, oready=1: flip req_tgl[3:0] same cycle
//     -> outputs ochan 0,1,2,3 on consecutive cycles; each ack flips once.
//  3. Fairness: ch0 and ch2 refire as soon as acked, oready=1 -> grants alternate 0,2,0,2; neither waits more than NUM_CHAN grants.
//  4. Backpressure: oready=0, FIFO_DEPTH=8, 9 events
//     -> olevel saturates at 8; 9th ack not flipped; raising oready delivers the 9th; no loss or duplicate.
//  5. Reset mid-stream: assert reset with olevel=5, req_tgl[2]=1
//     -> ovalid=0, olevel=0, ack_tgl=0 immediately; after release ch2 delivered exactly once.
//  6. VECTOR_XING_RX_ARB_COUNT_EN: 65537 events on ch0 -> ocount[15:0]=1. Without the macro, ocount stays 0.

Source files
------------

// File: rtl/vector_xing_pkg.sv
// Shared constants and width helpers for the vector_xing receive arbiter.
package vector_xing_pkg;

    localparam int COUNT_WIDTH = 16;

    // Index width that stays legal (>=1 bit) even for a single channel.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for a single request-toggle bit, async active-high reset.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/vector_xing_rx_arb.sv
// Multi-channel toggle-handshake receiver: sync, round-robin capture, FWFT output FIFO.
// Optional per-channel capture counters on ocount when VECTOR_XING_RX_ARB_COUNT_EN is defined.
module vector_xing_rx_arb
    import vector_xing_pkg::*;
#(
    parameter int NUM_CHAN    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CHAN_W     = clog2_min1(NUM_CHAN),
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CHAN-1:0]             req_tgl,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_CHAN-1:0]             ack_tgl,
    output logic [DATA_WIDTH-1:0]           odata,
    output logic [CHAN_W-1:0]               ochan,
    output logic                            ovalid,
    input  logic                            oready,
    output logic [LEVEL_W-1:0]              olevel,
    output logic [NUM_CHAN*COUNT_WIDTH-1:0] ocount
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [NUM_CHAN-1:0]   req_sync;
    logic [NUM_CHAN-1:0]   pending;
    logic [DATA_WIDTH-1:0] data_arr [NUM_CHAN];

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (req_tgl[c]),
            .q     (req_sync[c])
        );
        assign data_arr[c] = req_data[c*DATA_WIDTH +: DATA_WIDTH];
    end

    assign pending = req_sync ^ ack_tgl;

    logic [CHAN_W-1:0] last_grant;
    logic [CHAN_W-1:0] grant;
    logic [CHAN_W-1:0] cand;
    logic              grant_vld;

    always_comb begin
        grant     = last_grant;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_CHAN; i++) begin
            cand = CHAN_W'((int'(last_grant) + i) % NUM_CHAN);
            if (!grant_vld && pending[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    // Storage FIFO plus a registered head stage; olevel counts both together.
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [CHAN_W-1:0]     mem_chan [FIFO_DEPTH];
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic [ADDR_W:0]       mem_level;
    logic                  capture;
    logic                  pop;
    logic                  load;

    assign mem_level = wr_ptr - rd_ptr;
    assign olevel    = mem_level + LEVEL_W'(ovalid);
    assign capture   = grant_vld && (olevel < LEVEL_W'(FIFO_DEPTH));
    assign pop       = ovalid && oready;
    assign load      = (mem_level != '0) && (!ovalid || pop);

    always_ff @(posedge clk) begin
        if (capture) begin
            mem_data[wr_ptr[ADDR_W-1:0]] <= data_arr[grant];
            mem_chan[wr_ptr[ADDR_W-1:0]] <= grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ack_tgl    <= '0;
            last_grant <= CHAN_W'(NUM_CHAN - 1);
            ovalid     <= 1'b0;
            odata      <= '0;
            ochan      <= '0;
        end else begin
            if (capture) begin
                wr_ptr         <= wr_ptr + PTR_ONE;
                ack_tgl[grant] <= ~ack_tgl[grant];
                last_grant     <= grant;
            end
            if (load) begin
                odata  <= mem_data[rd_ptr[ADDR_W-1:0]];
                ochan  <= mem_chan[rd_ptr[ADDR_W-1:0]];
                rd_ptr <= rd_ptr + PTR_ONE;
                ovalid <= 1'b1;
            end else if (pop) begin
                ovalid <= 1'b0;
            end
        end
    end

`ifdef VECTOR_XING_RX_ARB_COUNT_EN
    logic [COUNT_WIDTH-1:0] cap_cnt [NUM_CHAN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                cap_cnt[c] <= '0;
            end
        end else if (capture) begin
            cap_cnt[grant] <= cap_cnt[grant] + COUNT_WIDTH'(1);
        end
    end

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_cnt
        assign ocount[c*COUNT_WIDTH +: COUNT_WIDTH] = cap_cnt[c];
    end
`else
    assign ocount = '0;
`endif

endmodule

// File: tb/tb_vector_xing_rx_arb.sv
// Directed bench for vector_xing_rx_arb with a queue-based delivery model checked every cycle.
`timescale 1ns/1ps
module tb_vector_xing_rx_arb;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int FD = 8;
    localparam int SS = 2;
    localparam int CW = 2;
    localparam int LW = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NC-1:0]    req_tgl = '0;
    logic [NC*DW-1:0] req_data = '0;
    logic [NC-1:0]    ack_tgl;
    logic [DW-1:0]    odata;
    logic [CW-1:0]    ochan;
    logic             ovalid;
    logic             oready = 1'b0;
    logic [LW-1:0]    olevel;
    logic [NC*16-1:0] ocount;

    vector_xing_rx_arb #(
        .NUM_CHAN(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .reset(reset), .req_tgl(req_tgl), .req_data(req_data),
        .ack_tgl(ack_tgl), .odata(odata), .ochan(ochan), .ovalid(ovalid),
        .oready(oready), .olevel(olevel), .ocount(ocount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [DW-1:0] data;
    } ev_t;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    ev_t exp_q[$];
    int  pop_chan[$];
    int  pop_cyc[$];
    int  sent_cnt[NC];

    int            lvl_model;
    logic [NC-1:0] prev_ack;
    logic [NC-1:0] prev_req;
    logic [NC-1:0] chg;
    logic          prev_pop;
    int            hit;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: captures are ack flips, the FIFO level is captures minus accepted pops,
    // and each accepted word must be the oldest outstanding event of its channel.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            lvl_model = 0;
            prev_ack  = '0;
            prev_req  = req_tgl;
            prev_pop  = 1'b0;
        end else begin
            chg = ack_tgl ^ prev_ack;
            for (int c = 0; c < NC; c++) begin
                if (chg[c]) begin
                    check($sformatf("ack_legal_ch%0d", c), prev_req[c] ^ prev_ack[c], 1);
                    lvl_model++;
                end
            end
            if (prev_pop) lvl_model--;
            check("olevel", olevel, lvl_model);
            check("ovalid_needs_level", ovalid && (olevel == 0), 0);
            if (ovalid && oready) begin
                hit = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (hit < 0 && exp_q[i].chan == ochan) hit = i;
                end
                check("pop_chan_known", hit >= 0, 1);
                if (hit >= 0) begin
                    check($sformatf("odata_ch%0d", ochan), odata, exp_q[hit].data);
                    exp_q.delete(hit);
                end
                pop_chan.push_back(int'(ochan));
                pop_cyc.push_back(cyc);
            end
            prev_pop = ovalid && oready;
            prev_ack = ack_tgl;
            prev_req = req_tgl;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        pop_chan.delete();
        pop_cyc.delete();
        for (int c = 0; c < NC; c++) sent_cnt[c] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        req_tgl = '0;
        clear_model();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic fire(input int c, input logic [DW-1:0] d);
        ev_t e;
        int  n;
        n = 0;
        while (req_tgl[c] != ack_tgl[c] && n < 60) begin
            tick(1);
            n++;
        end
        check($sformatf("fire_wait_ch%0d", c), req_tgl[c] == ack_tgl[c], 1);
        req_data[c*DW +: DW] = d;
        req_tgl[c]           = ~req_tgl[c];
        e.chan = CW'(c);
        e.data = d;
        exp_q.push_back(e);
        sent_cnt[c]++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        oready = 1'b1;
        while ((exp_q.size() != 0 || ovalid) && n < budget) begin
            tick(1);
            n++;
        end
        check("drain_all_delivered", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [NC*16-1:0] exp_cnt;

    initial begin
        clear_model();
        tick(2);
        check("rst_ovalid", ovalid, 0);
        check("rst_olevel", olevel, 0);
        check("rst_odata", odata, 0);
        check("rst_ochan", ochan, 0);
        check("rst_ack", ack_tgl, 0);
        check("rst_ocount", ocount, 0);
        reset = 1'b0;

        // single event: ovalid appears on the 4th edge after the flip
        oready = 1'b0;
        tick(1);
        fire(1, 32'hDEAD_BEEF);
        tick(3);
        check("t1_ovalid_edge3", ovalid, 0);
        check("t1_ack_edge3", ack_tgl, 4'b0010);
        tick(1);
        check("t1_ovalid_edge4", ovalid, 1);
        check("t1_odata", odata, 32'hDEAD_BEEF);
        check("t1_ochan", ochan, 1);
        check("t1_olevel", olevel, 1);
        drain(20);

        // all channels at once, from reset
        do_reset();
        oready = 1'b1;
        for (int c = 0; c < NC; c++) fire(c, 32'h1000_0000 + 32'(c));
        drain(50);
        check("t2_pops", pop_chan.size(), 4);
        for (int i = 0; i < 4 && i < pop_chan.size(); i++) begin
            check($sformatf("t2_order_%0d", i), pop_chan[i], i);
            check($sformatf("t2_consec_%0d", i), pop_cyc[i] - pop_cyc[0], i);
        end
        check("t2_acks", ack_tgl, 4'b1111);

        // fairness: ch0 and ch2 refire as soon as acked
        do_reset();
        oready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fire(0, 32'h3000_0000 + 32'(k));
            fire(2, 32'h3200_0000 + 32'(k));
        end
        drain(80);
        check("t3_pops", pop_chan.size(), 8);
        for (int i = 0; i < 8 && i < pop_chan.size(); i++) begin
            check($sformatf("t3_alt_%0d", i), pop_chan[i], (i % 2 == 0) ? 0 : 2);
        end

        // backpressure: nine events into an eight-deep FIFO
        do_reset();
        oready = 1'b0;
        for (int k = 0; k < 9; k++) fire(k % NC, 32'h4000_0000 + 32'(k));
        tick(10);
        check("t4_olevel_full", olevel, 8);
        check("t4_ack_9th_held", ack_tgl, 4'b0000);
        check("t4_head_data", odata, 32'h4000_0000);
        check("t4_head_chan", ochan, 0);
        drain(100);
        check("t4_pops", pop_chan.size(), 9);
        check("t4_ack_final", ack_tgl, 4'b0001);

        // reset mid-stream with ch2 request held high
        do_reset();
        oready = 1'b0;
        for (int c = 0; c < NC; c++) fire(c, 32'h5000_0000 + 32'(c));
        fire(0, 32'h5000_0010);
        tick(10);
        check("t5_olevel_pre", olevel, 5);
        reset   = 1'b1;
        req_tgl = 4'b0100;
        #1;
        check("t5_ovalid_rst", ovalid, 0);
        check("t5_olevel_rst", olevel, 0);
        check("t5_ack_rst", ack_tgl, 0);
        clear_model();
        begin
            ev_t e;
            e.chan = 2'd2;
            e.data = req_data[2*DW +: DW];
            exp_q.push_back(e);
            sent_cnt[2] = 1;
        end
        tick(2);
        reset = 1'b0;
        drain(50);
        tick(5);
        check("t5_pops", pop_chan.size(), 1);
        if (pop_chan.size() > 0) check("t5_chan", pop_chan[0], 2);
        check("t5_ack_final", ack_tgl, 4'b0100);

        // delivered counters
        do_reset();
        oready = 1'b1;
        for (int k = 0; k < 10; k++) fire(0, 32'h6000_0000 + 32'(k));
        for (int k = 0; k < 3; k++) fire(3, 32'h6300_0000 + 32'(k));
        drain(200);
        exp_cnt = '0;
`ifdef VECTOR_XING_RX_ARB_COUNT_EN
        for (int c = 0; c < NC; c++) exp_cnt[c*16 +: 16] = 16'(sent_cnt[c]);
        check("t6_ocount_lit", ocount, {16'd3, 16'd0, 16'd0, 16'd10});
`endif
        check("t6_ocount", ocount, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
